alu_seq_ctrl: RTL and testbench

Operation sequencer in front of the single-cycle ALU: accepts one operation request at a time and drives the ALU function select and operands (`alu_fn`, `alu_a`, `alu_b`). It runs single-cycle ALU ops in one pass, and multi-cycle ops (multiply, variable shifts) by iterating the ALU. It returns the result over a valid/ready response channel. It sits between the RISC decode/issue stage and the ALU.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/seq_iter_cnt.sv | 35 +++
 rtl/alu_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, ALU function codes and sequencer state encoding
// for the ALU operation sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLA  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SELB = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_SHLV = 4'd11;
  localparam logic [3:0] OP_SHRV = 4'd12;

  // ALU function codes coincide with the pass-through op codes
  localparam logic [3:0] FN_ADD  = OP_ADD;
  localparam logic [3:0] FN_SLA  = OP_SLA;
  localparam logic [3:0] FN_SRL  = OP_SRL;
  localparam logic [3:0] FN_SELB = OP_SELB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MUL,
    ST_SHIFT,
    ST_RESP
  } state_e;

  function automatic int unsigned calc_s(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_SHRV;
  endfunction

endpackage

// File: rtl/seq_iter_cnt.sv
// Loadable down-counter pacing the multi-cycle MUL and SHIFT iterations;
// last_o flags the final iteration.
module seq_iter_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Operation sequencer in front of a single-cycle ALU: single-cycle ops in one
// pass, MUL by shift-and-add and variable shifts by repeated 1-bit shifts.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_y,
  output logic         rsp_err,
  output logic [3:0]   alu_fn,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_y
);

  localparam int unsigned S  = calc_s(N);
  localparam int unsigned CW = S + 1;

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  // a_q holds A / multiplicand / shift work value; b_q holds B / multiplier
  logic [N-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [N-1:0] rsp_y_q, rsp_y_d;
  logic         rsp_err_q, rsp_err_d, rsp_valid_q, rsp_valid_d;
  logic         xfer, cnt_last, amt_zero;
  logic [CW-1:0] cnt_load_val;

  assign xfer     = req_valid && req_ready;
  assign amt_zero = (b_q[S-1:0] == '0);

  always_comb begin
    if (req_op == OP_MUL) begin
      cnt_load_val = CW'(N);
    end else if (req_b[S-1:0] == '0) begin
      cnt_load_val = CW'(1);
    end else begin
      cnt_load_val = {1'b0, req_b[S-1:0]};
    end
  end

  seq_iter_cnt #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (xfer),
    .load_val_i (cnt_load_val),
    .en_i       ((state_q == ST_MUL) || (state_q == ST_SHIFT)),
    .last_o     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (req_op == OP_MUL) begin
            state_d = ST_MUL;
          end else if ((req_op == OP_SHLV) || (req_op == OP_SHRV)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC:  state_d = ST_RESP;
      ST_MUL:   if (cnt_last) state_d = ST_RESP;
      ST_SHIFT: if (cnt_last) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    alu_fn    = FN_SELB;
    alu_a     = '0;
    alu_b     = '0;
    case (state_q)
      ST_EXEC: begin
        if (!op_illegal(op_q)) begin
          alu_fn = op_q;
          alu_a  = a_q;
          alu_b  = b_q;
        end
      end
      ST_MUL: begin
        alu_fn = FN_ADD;
        alu_a  = acc_q;
        alu_b  = b_q[0] ? a_q : '0;
      end
      ST_SHIFT: begin
        if (amt_zero) begin
          alu_b = a_q;
        end else begin
          alu_fn = (op_q == OP_SHLV) ? FN_SLA : FN_SRL;
          alu_a  = a_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    rsp_y_d     = rsp_y_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          acc_d = '0;
        end
      end
      ST_EXEC: begin
        rsp_y_d     = op_illegal(op_q) ? '0 : alu_y;
        rsp_err_d   = op_illegal(op_q);
        rsp_valid_d = 1'b1;
      end
      ST_MUL: begin
        acc_d = alu_y;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        if (cnt_last) begin
          rsp_y_d     = alu_y;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        a_d = alu_y;
        if (cnt_last) begin
          rsp_y_d     = alu_y;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      rsp_y_q     <= rsp_y_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl paired with a behavioral ALU (codes 0-9).
module tb_alu_seq_ctrl;

  localparam int unsigned N = 8;

  logic         clk, rst;
  logic         req_valid, req_ready;
  logic [3:0]   req_op;
  logic [N-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_y;
  logic         rsp_err;
  logic [3:0]   alu_fn;
  logic [N-1:0] alu_a, alu_b, alu_y;

  int n_vec;
  int n_err;

  alu_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .alu_fn    (alu_fn),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y)
  );

  always_comb begin
    case (alu_fn)
      4'd0:    alu_y = alu_a + alu_b;
      4'd1:    alu_y = alu_a - alu_b;
      4'd2:    alu_y = alu_a & alu_b;
      4'd3:    alu_y = alu_a | alu_b;
      4'd4:    alu_y = alu_a ^ alu_b;
      4'd5:    alu_y = ~alu_a;
      4'd6:    alu_y = alu_a << 1;
      4'd7:    alu_y = alu_a >> 1;
      4'd8:    alu_y = $unsigned($signed(alu_a) >>> 1);
      4'd9:    alu_y = alu_b;
      default: alu_y = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request with rsp_ready high; lat counts sampled cycles after
  // the acceptance edge up to and including the first one with rsp_valid.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] exp_y,
                       input logic exp_err, input int exp_lat, input logic [3:0] exp_fn);
    int   lat;
    logic [3:0] first_fn;
    logic fn_not9;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    lat      = 0;
    fn_not9  = 1'b0;
    first_fn = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0;
        first_fn  = alu_fn;
      end
      if (alu_fn != 4'd9) fn_not9 = 1'b1;
    end while (!rsp_valid && lat < 40);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " rsp_y"}, rsp_y, exp_y);
    chk({tag, " rsp_err"}, rsp_err, exp_err);
    chk({tag, " alu_fn"}, first_fn, exp_fn);
    if (exp_err) chk({tag, " alu_fn idle"}, fn_not9, 0);
    @(negedge clk);
    chk({tag, " ready back"}, {req_ready, rsp_valid}, 2'b10);
  endtask

  initial begin
    logic saw_valid;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #2;
    chk("reset ready/valid/err", {req_ready, rsp_valid, rsp_err}, 3'b100);
    chk("reset rsp_y", rsp_y, 0);
    chk("reset alu", {alu_fn, alu_a, alu_b}, {4'd9, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op("add",     4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 2, 4'd0);
    do_op("mul1",    4'd10, 8'h0D, 8'h0B, 8'h8F, 1'b0, 9, 4'd0);
    do_op("mul2",    4'd10, 8'hFF, 8'hFF, 8'h01, 1'b0, 9, 4'd0);
    do_op("mul0",    4'd10, 8'h00, 8'hA5, 8'h00, 1'b0, 9, 4'd0);
    do_op("shlv",    4'd11, 8'h81, 8'h0A, 8'h04, 1'b0, 3, 4'd6);
    do_op("shrv7",   4'd12, 8'h80, 8'h07, 8'h01, 1'b0, 8, 4'd7);
    do_op("shrv0",   4'd12, 8'h80, 8'h08, 8'h80, 1'b0, 2, 4'd9);
    do_op("sra",     4'd8,  8'h90, 8'h00, 8'hC8, 1'b0, 2, 4'd8);
    do_op("illegal", 4'd14, 8'h55, 8'h33, 8'h00, 1'b1, 2, 4'd9);

    // Backpressure: response held while rsp_ready is low, new request ignored
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd1; req_a = 8'h10; req_b = 8'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_a = 8'h01; req_b = 8'h01;
    @(negedge clk);
    chk("bp valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold", {rsp_valid, req_ready, rsp_err, rsp_y}, {3'b100, 8'hF0});
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp released", {req_ready, rsp_valid}, 2'b10);
    do_op("after bp", 4'd4, 8'hF0, 8'h0F, 8'hFF, 1'b0, 2, 4'd4);

    // Reset during the 4th MUL cycle
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd10; req_a = 8'h0D; req_b = 8'h0B;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mul busy", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst ready/valid/err", {req_ready, rsp_valid, rsp_err}, 3'b100);
    chk("rst rsp_y", rsp_y, 0);
    chk("rst alu", {alu_fn, alu_a, alu_b}, {4'd9, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    chk("no rsp after rst", saw_valid, 0);
    do_op("add post rst", 4'd0, 8'h02, 8'h03, 8'h05, 1'b0, 2, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
